// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory controller: funct3 encodings,
// FSM state enum and request decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_WR0  = 3'd2,
    ST_RD1  = 3'd3,
    ST_WR1  = 3'd4,
    ST_RESP = 3'd5
  } lsu_state_e;

  // Access size in bytes; 0 flags an encoding with no defined size.
  function automatic logic [2:0] size_decode(input logic [2:0] f3);
    logic [2:0] sz;
    case (f3[1:0])
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      2'b10:   sz = 3'd4;
      default: sz = 3'd0;
    endcase
    return sz;
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    return (f3[1:0] == 2'b11) || (f3 == 3'b110) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake between core and LSU plus the word-level memory bus.
interface lsu_mem_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] m_addr;
  logic        m_wr_en;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, m_addr, m_wr_en, m_wdata
  );

  modport mem (
    input  m_addr, m_wr_en, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering: merges store bytes into one or two old words
// and gathers/extends load bytes from them.
module lsu_lane_align (
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  input  logic        i_sign,
  input  logic [31:0] i_old0,
  input  logic [31:0] i_old1,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_new0,
  output logic [31:0] o_new1,
  output logic [31:0] o_load
);

  logic [31:0] w_raw;
  logic [2:0]  w_lane;

  // Access byte k lands in lane off+k; lanes past 3 wrap into the second word.
  always_comb begin
    o_new0 = i_old0;
    o_new1 = i_old1;
    w_raw  = 32'h0000_0000;
    w_lane = 3'd0;
    for (int k = 0; k < 4; k++) begin
      w_lane = {1'b0, i_off} + 3'(k);
      if (3'(k) < i_size) begin
        if (w_lane[2] == 1'b0) begin
          o_new0[{w_lane[1:0], 3'b000} +: 8] = i_wdata[8*k +: 8];
          w_raw[8*k +: 8]                    = i_old0[{w_lane[1:0], 3'b000} +: 8];
        end else begin
          o_new1[{w_lane[1:0], 3'b000} +: 8] = i_wdata[8*k +: 8];
          w_raw[8*k +: 8]                    = i_old1[{w_lane[1:0], 3'b000} +: 8];
        end
      end else begin
        w_lane = 3'd0;
      end
    end
  end

  always_comb begin
    o_load = w_raw;
    case (i_size)
      3'd1: begin
        if (i_sign) o_load = {{24{w_raw[7]}}, w_raw[7:0]};
        else        o_load = {24'h00_0000, w_raw[7:0]};
      end
      3'd2: begin
        if (i_sign) o_load = {{16{w_raw[15]}}, w_raw[15:0]};
        else        o_load = {16'h0000, w_raw[15:0]};
      end
      default: o_load = w_raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one byte-addressed request per handshake, turned into the
// word read / read-modify-write sequence on a combinational-read memory.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS      = 2048,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave lsu
);

  localparam logic [31:0] LP_MEM_WORDS = 32'(MEM_WORDS);
  localparam logic [31:0] LP_LAST_WORD = LP_MEM_WORDS - 32'd1;

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;
  logic        r_we;
  logic        r_sign;
  logic        r_span;
  logic [1:0]  r_off;
  logic [2:0]  r_size;
  logic [29:0] r_w0;
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic [31:0] r_word1;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [2:0]  w_req_size;
  logic [1:0]  w_req_off;
  logic [31:0] w_req_w0;
  logic        w_req_span;
  logic        w_req_full;
  logic        w_req_err;
  logic        w_accept;
  logic [31:0] w_old0;
  logic [31:0] w_old1;
  logic [31:0] w_new0;
  logic [31:0] w_new1;
  logic [31:0] w_load;
  logic [31:0] w_m_addr;
  logic [31:0] w_m_wdata;
  logic        w_wr;

  assign w_req_size = size_decode(lsu.req_funct3);
  assign w_req_off  = lsu.req_addr[1:0];
  assign w_req_w0   = {2'b00, lsu.req_addr[31:2]};
  assign w_req_span = ({1'b0, w_req_off} + w_req_size) > 3'd4;
  assign w_req_full = (w_req_size == 3'd4) && (w_req_off == 2'b00);
  assign w_req_err  = f3_illegal(lsu.req_funct3, lsu.req_we)
                   || (w_req_w0 >= LP_MEM_WORDS)
                   || (w_req_span && !ALLOW_MISALIGN)
                   || (w_req_span && (w_req_w0 == LP_LAST_WORD));
  assign w_accept   = lsu.req_valid && (r_state == ST_IDLE);

  // Read data is live during the read state itself, captured copy afterwards.
  assign w_old0 = (r_state == ST_RD0) ? lsu.m_rdata : r_word0;
  assign w_old1 = (r_state == ST_RD1) ? lsu.m_rdata : r_word1;

  lsu_lane_align u_align (
    .i_off   (r_off),
    .i_size  (r_size),
    .i_sign  (r_sign),
    .i_old0  (w_old0),
    .i_old1  (w_old1),
    .i_wdata (r_wdata),
    .o_new0  (w_new0),
    .o_new1  (w_new1),
    .o_load  (w_load)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!lsu.req_valid)                 w_state_nxt = ST_IDLE;
        else if (w_req_err)                 w_state_nxt = ST_RESP;
        else if (lsu.req_we && w_req_full)  w_state_nxt = ST_WR0;
        else                                w_state_nxt = ST_RD0;
      end
      ST_RD0: begin
        if (r_we)        w_state_nxt = ST_WR0;
        else if (r_span) w_state_nxt = ST_RD1;
        else             w_state_nxt = ST_RESP;
      end
      ST_WR0: begin
        if (r_span) w_state_nxt = ST_RD1;
        else        w_state_nxt = ST_RESP;
      end
      ST_RD1: begin
        if (r_we) w_state_nxt = ST_WR1;
        else      w_state_nxt = ST_RESP;
      end
      ST_WR1:  w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_m_addr  = 32'h0000_0000;
    w_m_wdata = 32'h0000_0000;
    w_wr      = 1'b0;
    case (r_state)
      ST_RD0: w_m_addr = {2'b00, r_w0};
      ST_WR0: begin
        w_m_addr  = {2'b00, r_w0};
        w_m_wdata = w_new0;
        w_wr      = 1'b1;
      end
      ST_RD1: w_m_addr = {2'b00, r_w0} + 32'd1;
      ST_WR1: begin
        w_m_addr  = {2'b00, r_w0} + 32'd1;
        w_m_wdata = w_new1;
        w_wr      = 1'b1;
      end
      default: w_m_addr = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_sign      <= 1'b0;
      r_span      <= 1'b0;
      r_off       <= 2'b00;
      r_size      <= 3'd0;
      r_w0        <= 30'd0;
      r_wdata     <= 32'h0000_0000;
      r_word0     <= 32'h0000_0000;
      r_word1     <= 32'h0000_0000;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= lsu.req_we;
        r_sign  <= ~lsu.req_funct3[2];
        r_span  <= w_req_span;
        r_off   <= w_req_off;
        r_size  <= w_req_size;
        r_w0    <= lsu.req_addr[31:2];
        r_wdata <= lsu.req_wdata;
      end
      if (r_state == ST_RD0) r_word0 <= lsu.m_rdata;
      if (r_state == ST_RD1) r_word1 <= lsu.m_rdata;
      // Only the error path enters RESP straight from IDLE; only loads from a read state.
      if ((w_state_nxt == ST_RESP) && (r_state != ST_RESP)) begin
        r_rsp_err   <= (r_state == ST_IDLE);
        r_rsp_rdata <= ((r_state == ST_RD0) || (r_state == ST_RD1)) ? w_load : 32'h0000_0000;
      end
    end
  end

  assign lsu.req_ready = (r_state == ST_IDLE);
  assign lsu.rsp_valid = (r_state == ST_RESP);
  assign lsu.rsp_rdata = r_rsp_rdata;
  assign lsu.rsp_err   = r_rsp_err;
  assign lsu.m_addr    = w_m_addr;
  assign lsu.m_wdata   = w_m_wdata;
  assign lsu.m_wr_en   = w_wr && rst_n;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized traffic
// checked against a byte-addressed reference model of the memory.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl_if ifa ();
  lsu_mem_ctrl_if ifb ();

  lsu_mem_ctrl #(.MEM_WORDS(2048), .ALLOW_MISALIGN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .lsu(ifa));
  lsu_mem_ctrl #(.MEM_WORDS(2048), .ALLOW_MISALIGN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .lsu(ifb));

  logic        drv_valid = 1'b0;
  logic        drv_sel = 1'b0;
  logic        drv_we = 1'b0;
  logic [2:0]  drv_f3 = 3'd0;
  logic [31:0] drv_addr = 32'd0;
  logic [31:0] drv_wdata = 32'd0;

  assign ifa.req_valid  = drv_valid & ~drv_sel;
  assign ifb.req_valid  = drv_valid & drv_sel;
  assign ifa.req_we     = drv_we;
  assign ifb.req_we     = drv_we;
  assign ifa.req_funct3 = drv_f3;
  assign ifb.req_funct3 = drv_f3;
  assign ifa.req_addr   = drv_addr;
  assign ifb.req_addr   = drv_addr;
  assign ifa.req_wdata  = drv_wdata;
  assign ifb.req_wdata  = drv_wdata;

  logic        o_ready, o_rsp_valid, o_err, o_wr;
  logic [31:0] o_rdata, o_maddr, o_mwdata;
  assign o_ready     = drv_sel ? ifb.req_ready : ifa.req_ready;
  assign o_rsp_valid = drv_sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign o_err       = drv_sel ? ifb.rsp_err   : ifa.rsp_err;
  assign o_rdata     = drv_sel ? ifb.rsp_rdata : ifa.rsp_rdata;
  assign o_wr        = drv_sel ? ifb.m_wr_en   : ifa.m_wr_en;
  assign o_maddr     = drv_sel ? ifb.m_addr    : ifa.m_addr;
  assign o_mwdata    = drv_sel ? ifb.m_wdata   : ifa.m_wdata;

  logic [31:0] mem_a [0:2047];
  logic [31:0] mem_b [0:2047];
  logic [31:0] exp_mem [0:2047];
  logic        preset = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h4433_2211;
    else if (i == 2) return 32'h8877_6655;
    else return 32'(i) * 32'h9E37_79B1;
  endfunction

  always @(posedge clk) begin
    if (preset) begin
      for (int i = 0; i < 2048; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (ifa.m_wr_en) mem_a[ifa.m_addr[10:0]] <= ifa.m_wdata;
      if (ifb.m_wr_en) mem_b[ifb.m_addr[10:0]] <= ifb.m_wdata;
    end
  end

  assign ifa.m_rdata = mem_a[ifa.m_addr[10:0]];
  assign ifb.m_rdata = mem_b[ifb.m_addr[10:0]];

  task automatic do_preset();
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;
    for (int i = 0; i < 2048; i++) exp_mem[i] = init_word(i);
  endtask

  // Reference: touched bytes are addr..addr+size-1; error if any lies outside memory.
  task automatic model_op(input bit allow, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output bit err, output logic [31:0] rd,
                          output int lat, output int wrs);
    int size, first, last, b;
    logic [31:0] v;
    case (f3[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      2'b10:   size = 4;
      default: size = 0;
    endcase
    err = (size == 0) || (f3 == 3'b110) || (we && f3[2]);
    first = int'(addr >> 2);
    last = (size > 0) ? int'((addr + 32'(size) - 32'd1) >> 2) : first;
    if (first >= 2048 || last >= 2048) err = 1'b1;
    if (last != first && !allow) err = 1'b1;
    rd = 32'd0;
    wrs = 0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int k = 0; k < size; k++) begin
        b = int'(addr) + k;
        exp_mem[b / 4][(b % 4) * 8 +: 8] = wd[8*k +: 8];
      end
      wrs = (last != first) ? 2 : 1;
      lat = (last != first) ? 5 : ((size == 4) ? 2 : 3);
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) begin
        b = int'(addr) + k;
        v[8*k +: 8] = exp_mem[b / 4][(b % 4) * 8 +: 8];
      end
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
      lat = (last != first) ? 3 : 2;
    end
  endtask

  task automatic issue(input bit sel, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er,
                       output int wrs, output logic [31:0] a1, output logic [31:0] a2);
    @(negedge clk);
    drv_sel = sel;
    drv_we = we;
    drv_f3 = f3;
    drv_addr = addr;
    drv_wdata = wd;
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_we = 1'($urandom);
    drv_f3 = 3'($urandom);
    drv_addr = $urandom;
    drv_wdata = $urandom;
    lat = -1; rd = 32'd0; er = 1'b0; wrs = 0; a1 = 32'd0; a2 = 32'd0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) a1 = o_maddr;
      if (n == 2) a2 = o_maddr;
      if (o_wr) wrs++;
      if (o_rsp_valid) begin
        lat = n; rd = o_rdata; er = o_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({o_ready, o_rsp_valid, o_err, o_wr} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 1000", {o_ready, o_rsp_valid, o_err, o_wr});
    end
    checks++;
    if ({o_rdata, o_maddr, o_mwdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h exp 0", o_rdata, o_maddr, o_mwdata);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [6];
    logic [31:0] adr [6];
    logic [31:0] exr [6];
    int          exl [6];
    int lat, wrs; logic [31:0] rd, a1, a2; logic er;
    f3s = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b101, 3'b001};
    adr = '{32'h4, 32'h7, 32'hB, 32'hB, 32'hA, 32'h7};
    exr = '{32'h4433_2211, 32'h0000_0044, 32'hFFFF_FF88, 32'h0000_0088, 32'h0000_8877, 32'h0000_5544};
    exl = '{2, 2, 2, 2, 2, 3};
    do_preset();
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 1'b0, f3s[i], adr[i], 32'd0, lat, rd, er, wrs, a1, a2);
      checks++;
      if (rd !== exr[i] || er !== 1'b0 || lat != exl[i] || wrs != 0) begin
        errors++;
        $display("FAIL load_%0d got rd=%h err=%b lat=%0d wr=%0d exp rd=%h err=0 lat=%0d wr=0",
                 i, rd, er, lat, wrs, exr[i], exl[i]);
      end
      if (i == 5) begin
        checks++;
        if (a1 !== 32'd1 || a2 !== 32'd2) begin
          errors++;
          $display("FAIL span_load_addr got %h %h exp 1 2", a1, a2);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b0 || o_rdata !== 32'h0000_5544) begin
      errors++;
      $display("FAIL rsp_hold got valid=%b rd=%h exp valid=0 rd=00005544", o_rsp_valid, o_rdata);
    end
  endtask

  task automatic test_stores();
    int lat, wrs; logic [31:0] rd, a1, a2; logic er;
    do_preset();
    issue(1'b0, 1'b1, 3'b001, 32'h6, 32'h0000_BEEF, lat, rd, er, wrs, a1, a2);
    @(negedge clk);
    checks++;
    if (mem_a[1] !== 32'hBEEF_2211 || lat != 3 || wrs != 1 || er !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL sh_rmw got w1=%h lat=%0d wr=%0d err=%b rd=%h exp w1=beef2211 lat=3 wr=1 err=0 rd=0",
               mem_a[1], lat, wrs, er, rd);
    end
    issue(1'b0, 1'b1, 3'b010, 32'h6, 32'hDEAD_BEEF, lat, rd, er, wrs, a1, a2);
    @(negedge clk);
    checks++;
    if (mem_a[1] !== 32'hBEEF_2211 || mem_a[2] !== 32'h8877_DEAD || lat != 5 || wrs != 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL sw_span got w1=%h w2=%h lat=%0d wr=%0d err=%b exp beef2211 8877dead 5 2 0",
               mem_a[1], mem_a[2], lat, wrs, er);
    end
    checks++;
    if (mem_a[3] !== init_word(3) || mem_a[0] !== init_word(0)) begin
      errors++;
      $display("FAIL neighbours got %h %h exp %h %h", mem_a[0], mem_a[3], init_word(0), init_word(3));
    end
    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678, lat, rd, er, wrs, a1, a2);
    @(negedge clk);
    checks++;
    if (mem_a[4] !== 32'h1234_5678 || lat != 2 || wrs != 1) begin
      errors++;
      $display("FAIL sw_aligned got w4=%h lat=%0d wr=%0d exp 12345678 2 1", mem_a[4], lat, wrs);
    end
  endtask

  task automatic test_no_misalign();
    int lat, wrs; logic [31:0] rd, a1, a2; logic er;
    do_preset();
    issue(1'b1, 1'b1, 3'b010, 32'h6, 32'hDEAD_BEEF, lat, rd, er, wrs, a1, a2);
    @(negedge clk);
    checks++;
    if (er !== 1'b1 || lat != 1 || wrs != 0 || rd !== 32'd0 ||
        mem_b[1] !== 32'h4433_2211 || mem_b[2] !== 32'h8877_6655) begin
      errors++;
      $display("FAIL nomis_sw got err=%b lat=%0d wr=%0d rd=%h w1=%h w2=%h exp 1 1 0 0 44332211 88776655",
               er, lat, wrs, rd, mem_b[1], mem_b[2]);
    end
    issue(1'b1, 1'b0, 3'b010, 32'h4, 32'd0, lat, rd, er, wrs, a1, a2);
    checks++;
    if (er !== 1'b0 || lat != 2 || rd !== 32'h4433_2211) begin
      errors++;
      $display("FAIL nomis_lw got err=%b lat=%0d rd=%h exp 0 2 44332211", er, lat, rd);
    end
    drv_sel = 1'b0;
  endtask

  task automatic test_errors();
    logic [2:0]  f3s [4];
    logic [31:0] adr [4];
    bit          wes [4];
    int lat, wrs; logic [31:0] rd, a1, a2; logic er;
    f3s = '{3'b011, 3'b010, 3'b010, 3'b100};
    adr = '{32'h4, 32'h2000, 32'h1FFE, 32'h8};
    wes = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, wes[i], f3s[i], adr[i], 32'hFFFF_FFFF, lat, rd, er, wrs, a1, a2);
      checks++;
      if (er !== 1'b1 || lat != 1 || wrs != 0 || rd !== 32'd0) begin
        errors++;
        $display("FAIL err_%0d got err=%b lat=%0d wr=%0d rd=%h exp err=1 lat=1 wr=0 rd=0", i, er, lat, wrs, rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, wrs; logic [31:0] rd, a1, a2; logic er;
    bit seen;
    do_preset();
    @(negedge clk);
    drv_sel = 1'b0; drv_we = 1'b1; drv_f3 = 3'b000; drv_addr = 32'h4; drv_wdata = 32'h0000_005A;
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_wr !== 1'b1) begin
      errors++;
      $display("FAIL wr_before_reset got %b exp 1", o_wr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_wr !== 1'b0) begin
      errors++;
      $display("FAIL wr_gated got %b exp 0", o_wr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b exp 1", o_ready);
    end
    for (int n = 0; n < 4; n++) begin
      if (o_rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen || mem_a[1] !== 32'h4433_2211) begin
      errors++;
      $display("FAIL abort got rsp_seen=%b w1=%h exp 0 44332211", seen, mem_a[1]);
    end
    issue(1'b0, 1'b0, 3'b010, 32'h4, 32'd0, lat, rd, er, wrs, a1, a2);
    checks++;
    if (rd !== 32'h4433_2211 || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL lw_after_abort got rd=%h err=%b lat=%0d exp 44332211 0 2", rd, er, lat);
    end
  endtask

  task automatic test_random();
    logic [2:0] lv [5];
    bit we, e_err; logic [2:0] f3; logic [31:0] addr, wd, e_rd, rd, a1, a2; logic er;
    int e_lat, e_wrs, lat, wrs, k, w;
    lv = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    do_preset();
    for (int it = 0; it < 250; it++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = lv[$urandom_range(0, 2)];
      else f3 = lv[$urandom_range(0, 4)];
      k = $urandom_range(0, 19);
      if (k == 0) addr = 32'h1FFC + 32'($urandom_range(0, 3));
      else if (k == 1) addr = 32'h2000 + 32'($urandom_range(0, 255));
      else addr = 32'($urandom_range(0, 63));
      wd = $urandom;
      model_op(1'b1, we, f3, addr, wd, e_err, e_rd, e_lat, e_wrs);
      issue(1'b0, we, f3, addr, wd, lat, rd, er, wrs, a1, a2);
      checks++;
      if (er !== e_err || rd !== e_rd || lat != e_lat || wrs != e_wrs) begin
        errors++;
        $display("FAIL rand_%0d we=%b f3=%b a=%h got err=%b rd=%h lat=%0d wr=%0d exp err=%b rd=%h lat=%0d wr=%0d",
                 it, we, f3, addr, er, rd, lat, wrs, e_err, e_rd, e_lat, e_wrs);
      end
      if (we && !e_err) begin
        @(negedge clk);
        w = int'(addr >> 2);
        checks++;
        if (mem_a[w] !== exp_mem[w] || (w < 2047 && mem_a[w+1] !== exp_mem[w+1])) begin
          errors++;
          $display("FAIL rand_mem_%0d a=%h got %h %h exp %h %h", it, addr, mem_a[w],
                   (w < 2047) ? mem_a[w+1] : 32'd0, exp_mem[w], (w < 2047) ? exp_mem[w+1] : 32'd0);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    preset = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    preset = 1'b0;
    test_loads();
    test_stores();
    test_no_misalign();
    test_errors();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
